// File: rtl/tag_pkg.sv
// rtl/tag_pkg.sv - shared tag constants, state encoding and size defaults
package tag_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 3;
  localparam int IDXW_DEF  = 4;

  localparam logic TAG_L = 1'b0;
  localparam logic TAG_H = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    RETAG = 2'd2
  } state_t;

endpackage

// File: rtl/tag_port_check.sv
// rtl/tag_port_check.sv - combinational access permission for one port
module tag_port_check
  import tag_pkg::*;
(
  input  logic level,
  input  logic we,
  input  logic tag,
  output logic deny
);

  // Low may write up but never read H; high may read anything but never write down.
  assign deny = (level == TAG_L) ? (~we & (tag == TAG_H))
                                 : (we & (tag == TAG_L));

endmodule

// File: rtl/tagged_array_ctrl.sv
// rtl/tagged_array_ctrl.sv - time-sliced two-level tagged array with scrub-before-downgrade retag
module tagged_array_ctrl
  import tag_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lo_valid,
  input  logic             lo_we,
  input  logic [IDXW-1:0]  lo_idx,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             lo_ready,
  output logic             lo_rvalid,
  output logic [WIDTH-1:0] lo_rdata,
  output logic             lo_deny,
  input  logic             hi_valid,
  input  logic             hi_we,
  input  logic [IDXW-1:0]  hi_idx,
  input  logic [WIDTH-1:0] hi_wdata,
  output logic             hi_ready,
  output logic             hi_rvalid,
  output logic [WIDTH-1:0] hi_rdata,
  output logic             hi_deny,
  input  logic             cfg_valid,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic             cfg_tag,
  output logic             cfg_ready,
  output logic [DEPTH-1:0] tags_out
);

  state_t                     state;
  logic                       slot;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]           tags;
  logic [IDXW-1:0]            cfg_idx_q;
  logic                       cfg_tag_q;
  logic                       idle;
  logic                       lo_fire, hi_fire;
  logic                       lo_den, hi_den;

  // Slot ownership is fixed, so one port's latency never depends on the other's traffic.
  assign idle      = (state == IDLE);
  assign lo_ready  = ~rst & idle & ~slot & ~cfg_valid;
  assign hi_ready  = ~rst & idle &  slot & ~cfg_valid;
  assign cfg_ready = ~rst & idle & cfg_valid;
  assign lo_fire   = lo_valid & lo_ready;
  assign hi_fire   = hi_valid & hi_ready;
  assign tags_out  = tags;

  tag_port_check u_lo_check (
    .level (TAG_L),
    .we    (lo_we),
    .tag   (tags[lo_idx]),
    .deny  (lo_den)
  );

  tag_port_check u_hi_check (
    .level (TAG_H),
    .we    (hi_we),
    .tag   (tags[hi_idx]),
    .deny  (hi_den)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= 1'b0;
      mem       <= '0;
      tags      <= '0;
      cfg_idx_q <= '0;
      cfg_tag_q <= TAG_L;
      lo_rvalid <= 1'b0;
      lo_rdata  <= '0;
      lo_deny   <= 1'b0;
      hi_rvalid <= 1'b0;
      hi_rdata  <= '0;
      hi_deny   <= 1'b0;
    end else begin
      slot      <= ~slot;
      lo_rvalid <= lo_fire;
      lo_deny   <= lo_fire & lo_den;
      lo_rdata  <= (lo_fire & ~lo_we & ~lo_den) ? mem[lo_idx] : '0;
      hi_rvalid <= hi_fire;
      hi_deny   <= hi_fire & hi_den;
      hi_rdata  <= (hi_fire & ~hi_we & ~hi_den) ? mem[hi_idx] : '0;

      if (lo_fire & lo_we & ~lo_den) mem[lo_idx] <= lo_wdata;
      if (hi_fire & hi_we & ~hi_den) mem[hi_idx] <= hi_wdata;

      case (state)
        IDLE: begin
          if (cfg_ready) begin
            cfg_idx_q <= cfg_idx;
            cfg_tag_q <= cfg_tag;
            // H data must be erased before its entry becomes low-readable.
            state     <= (tags[cfg_idx] == TAG_H && cfg_tag == TAG_L) ? SCRUB : RETAG;
          end
        end
        SCRUB: begin
          mem[cfg_idx_q] <= '0;
          state          <= RETAG;
        end
        RETAG: begin
          tags[cfg_idx_q] <= cfg_tag_q;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tagged_array_ctrl.sv
// tb/tb_tagged_array_ctrl.sv - directed self-checking bench for tagged_array_ctrl
module tb_tagged_array_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lo_valid = 1'b0, lo_we = 1'b0;
  logic [3:0]  lo_idx = '0;
  logic [2:0]  lo_wdata = '0;
  logic        lo_ready, lo_rvalid, lo_deny;
  logic [2:0]  lo_rdata;
  logic        hi_valid = 1'b0, hi_we = 1'b0;
  logic [3:0]  hi_idx = '0;
  logic [2:0]  hi_wdata = '0;
  logic        hi_ready, hi_rvalid, hi_deny;
  logic [2:0]  hi_rdata;
  logic        cfg_valid = 1'b0, cfg_tag = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic        cfg_ready;
  logic [15:0] tags_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tagged_array_ctrl dut (
    .clk(clk), .rst(rst),
    .lo_valid(lo_valid), .lo_we(lo_we), .lo_idx(lo_idx), .lo_wdata(lo_wdata),
    .lo_ready(lo_ready), .lo_rvalid(lo_rvalid), .lo_rdata(lo_rdata), .lo_deny(lo_deny),
    .hi_valid(hi_valid), .hi_we(hi_we), .hi_idx(hi_idx), .hi_wdata(hi_wdata),
    .hi_ready(hi_ready), .hi_rvalid(hi_rvalid), .hi_rdata(hi_rdata), .hi_deny(hi_deny),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_tag(cfg_tag), .cfg_ready(cfg_ready),
    .tags_out(tags_out)
  );

  // One request on either port; returns the response sampled the cycle after accept.
  task automatic req(input logic hi, input logic we, input logic [3:0] idx, input logic [2:0] wd,
                     output logic rv, output logic [2:0] rd, output logic dn);
    int n = 0;
    @(negedge clk);
    if (hi) begin hi_valid = 1; hi_we = we; hi_idx = idx; hi_wdata = wd; end
    else    begin lo_valid = 1; lo_we = we; lo_idx = idx; lo_wdata = wd; end
    #1;
    while (!(hi ? hi_ready : lo_ready) && n < 20) begin @(negedge clk); #1; n++; end
    compared++;
    if (!(hi ? hi_ready : lo_ready)) begin
      mismatched++;
      $display("FAIL req_accept_timeout port=%0d got ready=0 expected ready=1", hi);
    end
    @(negedge clk);
    #1;
    if (hi) begin rv = hi_rvalid; rd = hi_rdata; dn = hi_deny; hi_valid = 0; end
    else    begin rv = lo_rvalid; rd = lo_rdata; dn = lo_deny; lo_valid = 0; end
  endtask

  // Retag with both ports requesting reads; counts cycles where neither port is ready.
  task automatic cfg_req(input logic [3:0] idx, input logic tag,
                         output logic acc, output logic prio_ok, output int blocked);
    @(negedge clk);
    cfg_valid = 1; cfg_idx = idx; cfg_tag = tag;
    lo_valid = 1; lo_we = 0; lo_idx = 0; hi_valid = 1; hi_we = 0; hi_idx = 0;
    #1;
    acc = cfg_ready;
    prio_ok = !lo_ready && !hi_ready;
    @(negedge clk);
    cfg_valid = 0; cfg_idx = 4'hf; cfg_tag = ~tag;
    #1;
    blocked = 0;
    for (int i = 0; i < 4; i++) begin
      if (!lo_ready && !hi_ready) blocked++;
      else break;
      @(negedge clk);
      #1;
    end
    lo_valid = 0; hi_valid = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; lo_valid = 1; hi_valid = 1; cfg_valid = 1;
    @(negedge clk); @(negedge clk); #1;
    compared++;
    if ({lo_ready, hi_ready, cfg_ready} !== 3'b000) begin
      mismatched++; $display("FAIL reset_ready got %b expected 000", {lo_ready, hi_ready, cfg_ready});
    end
    compared++;
    if ({lo_rvalid, lo_deny, lo_rdata, hi_rvalid, hi_deny, hi_rdata} !== 10'b0) begin
      mismatched++; $display("FAIL reset_resp got %b expected 0", {lo_rvalid, lo_deny, lo_rdata, hi_rvalid, hi_deny, hi_rdata});
    end
    compared++;
    if (tags_out !== 16'h0000) begin
      mismatched++; $display("FAIL reset_tags got %h expected 0000", tags_out);
    end
    lo_valid = 0; hi_valid = 0; cfg_valid = 0;
    rst = 0;
  endtask

  task automatic test_low_rw();
    logic rv, dn; logic [2:0] rd;
    req(0, 1, 4'd3, 3'd5, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b0}) begin
      mismatched++; $display("FAIL lo_write_resp got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=0", rv, rd, dn);
    end
    req(0, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd5, 1'b0}) begin
      mismatched++; $display("FAIL lo_read_l got rv=%b rd=%0d dn=%b expected rv=1 rd=5 dn=0", rv, rd, dn);
    end
  endtask

  task automatic test_upgrade();
    logic acc, pok, rv, dn; logic [2:0] rd; int blk;
    cfg_req(4'd3, 1'b1, acc, pok, blk);
    compared++;
    if ({acc, pok} !== 2'b11) begin
      mismatched++; $display("FAIL up_accept got acc=%b prio=%b expected 1 1", acc, pok);
    end
    compared++;
    if (blk !== 1) begin
      mismatched++; $display("FAIL up_blocked_cycles got %0d expected 1", blk);
    end
    compared++;
    if (tags_out !== 16'h0008) begin
      mismatched++; $display("FAIL up_tags got %h expected 0008", tags_out);
    end
    req(0, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b1}) begin
      mismatched++; $display("FAIL lo_read_h got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=1", rv, rd, dn);
    end
    req(1, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd5, 1'b0}) begin
      mismatched++; $display("FAIL hi_read_h got rv=%b rd=%0d dn=%b expected rv=1 rd=5 dn=0", rv, rd, dn);
    end
  endtask

  task automatic test_write_rules();
    logic rv, dn; logic [2:0] rd;
    req(0, 1, 4'd4, 3'd2, rv, rd, dn);
    req(1, 1, 4'd4, 3'd7, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b1}) begin
      mismatched++; $display("FAIL hi_write_l got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=1", rv, rd, dn);
    end
    req(0, 0, 4'd4, 3'd0, rv, rd, dn);
    compared++;
    if ({rd, dn} !== {3'd2, 1'b0}) begin
      mismatched++; $display("FAIL hi_write_l_unchanged got rd=%0d dn=%b expected rd=2 dn=0", rd, dn);
    end
    req(1, 1, 4'd3, 3'd6, rv, rd, dn);
    compared++;
    if (dn !== 1'b0) begin
      mismatched++; $display("FAIL hi_write_h got dn=%b expected 0", dn);
    end
    req(1, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if (rd !== 3'd6) begin
      mismatched++; $display("FAIL hi_write_h_data got %0d expected 6", rd);
    end
    req(0, 1, 4'd3, 3'd5, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b0}) begin
      mismatched++; $display("FAIL lo_write_up got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=0", rv, rd, dn);
    end
    req(1, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if (rd !== 3'd5) begin
      mismatched++; $display("FAIL lo_write_up_data got %0d expected 5", rd);
    end
  endtask

  task automatic test_downgrade();
    logic acc, pok, rv, dn; logic [2:0] rd; int blk;
    cfg_req(4'd3, 1'b0, acc, pok, blk);
    compared++;
    if (blk !== 2) begin
      mismatched++; $display("FAIL down_blocked_cycles got %0d expected 2", blk);
    end
    compared++;
    if (tags_out !== 16'h0000) begin
      mismatched++; $display("FAIL down_tags got %h expected 0000", tags_out);
    end
    req(0, 0, 4'd3, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b0}) begin
      mismatched++; $display("FAIL down_scrubbed got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=0", rv, rd, dn);
    end
  endtask

  task automatic test_slot_independence();
    logic [15:0] lr [2];
    logic [15:0] rvv[2];
    logic        rd_ok;
    for (int run = 0; run < 2; run++) begin
      int n = 0;
      @(negedge clk);
      lo_valid = 1; lo_we = 0; lo_idx = 4'd4; #1;
      while (!lo_ready && n < 4) begin @(negedge clk); #1; n++; end
      rd_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        hi_valid = (run == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        hi_we = 0; hi_idx = 4'($urandom_range(15, 0));
        #1;
        lr[run][i]  = lo_ready;
        rvv[run][i] = lo_rvalid;
        if (lo_rvalid && (lo_rdata !== 3'd2 || lo_deny !== 1'b0)) rd_ok = 1'b0;
        @(negedge clk);
      end
      lo_valid = 0; hi_valid = 0;
      compared++;
      if (lr[run] !== 16'h5555) begin
        mismatched++; $display("FAIL slot_lo_ready run=%0d got %h expected 5555", run, lr[run]);
      end
      compared++;
      if (rvv[run] !== 16'haaaa) begin
        mismatched++; $display("FAIL slot_lo_rvalid run=%0d got %h expected aaaa", run, rvv[run]);
      end
      compared++;
      if (rd_ok !== 1'b1) begin
        mismatched++; $display("FAIL slot_lo_rdata run=%0d got bad data expected 2", run);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_scrub();
    logic acc, pok, rv, dn; logic [2:0] rd; int blk;
    req(0, 1, 4'd5, 3'd3, rv, rd, dn);
    cfg_req(4'd5, 1'b1, acc, pok, blk);
    compared++;
    if (tags_out !== 16'h0020) begin
      mismatched++; $display("FAIL pre_scrub_tags got %h expected 0020", tags_out);
    end
    @(negedge clk);
    cfg_valid = 1; cfg_idx = 4'd5; cfg_tag = 1'b0; #1;
    compared++;
    if (cfg_ready !== 1'b1) begin
      mismatched++; $display("FAIL scrub_cfg_accept got %b expected 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0; lo_valid = 1; lo_we = 0; lo_idx = 4'd5; #1;
    compared++;
    if (tags_out !== 16'h0000) begin
      mismatched++; $display("FAIL rst_scrub_tags got %h expected 0000", tags_out);
    end
    compared++;
    if (lo_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_scrub_idle got lo_ready=%b expected 1", lo_ready);
    end
    lo_valid = 0;
    req(0, 0, 4'd5, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b0}) begin
      mismatched++; $display("FAIL rst_scrub_read5 got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=0", rv, rd, dn);
    end
    req(1, 0, 4'd4, 3'd0, rv, rd, dn);
    compared++;
    if ({rv, rd, dn} !== {1'b1, 3'd0, 1'b0}) begin
      mismatched++; $display("FAIL rst_scrub_read4 got rv=%b rd=%0d dn=%b expected rv=1 rd=0 dn=0", rv, rd, dn);
    end
  endtask

  initial begin
    test_reset();
    test_low_rw();
    test_upgrade();
    test_write_rules();
    test_downgrade();
    test_slot_independence();
    test_reset_in_scrub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
